sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
//  Shares one SRAM-like slave port, the input of the AXI bridge, between the inst fetch master and the data master.
//  - Picks one request per address handshake.
//  - Holds the grant stable until the downstream address handshake completes.
//  - Keeps an in-order FIFO of accepted requester IDs so each downstream data_ok returns to the right master.
// PARAMETERS
//  OUTS_DEPTH  2  max accepted-but-uncompleted transactions (ID FIFO depth, power of 2, >=2)
//  ADDR_W      32 address/data width
// PORTS
//  clk           in   1       clock, all logic on posedge
//  resetn        in   1       synchronous reset, active-low
//  inst_req      in   1       inst read request (read-only master, size fixed 2'b10)
//  inst_addr     in   ADDR_W  inst read address
//  inst_addr_ok  out  1       inst request accepted this cycle
//  inst_data_ok  out  1       inst read data valid this cycle
//  data_req      in   1       data request
//  data_wr       in   1       1=write 0=read
//  data_size     in   2       0=byte 1=half 2=word
//  data_wstrb    in   4       write byte enables
//  data_addr     in   ADDR_W  data address
//  data_wdata    in   ADDR_W  write data
//  data_addr_ok  out  1       data request accepted this cycle
//  data_data_ok  out  1       data read data valid / write done this cycle
//  rdata         out  ADDR_W  s_rdata pass-through, shared by both masters
//  s_req         out  1       downstream request
//  s_wr/s_size/s_wstrb/s_addr/s_wdata  out  1/2/4/ADDR_W/ADDR_W  muxed from the granted master (inst: wr=0, size=2, wstrb=0, wdata=0)
//  s_addr_ok     in   1       downstream accepted s_req
//  s_data_ok     in   1       downstream completed oldest transaction
//  s_rdata       in   ADDR_W  downstream read data
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): cnt=0, FIFO pointers=0, lock=0, grant=data.
//    All outputs 0 in the reset cycle and after it until a new request arrives.
//  - Arbitration is combinational, with zero added latency.
//    - When lock=0, data wins if data_req, otherwise inst wins.
//    - When lock=1, the registered grant is used, whatever the current requests.
//  - s_req = (granted master's req) & (cnt != OUTS_DEPTH).
//  - Lock register:
//    - set when s_req & ~s_addr_ok, capturing the grant;
//    - cleared on the s_req & s_addr_ok cycle.
//    - Masters must hold their request stable while unaccepted. This block does not check that.
//  - x_addr_ok = s_req & s_addr_ok & (grant==x). At most one of the two is high per cycle.
//  - On accept, push grant ID (0=inst, 1=data) into the FIFO at wptr. cnt++.
//  - On s_data_ok with cnt != 0:
//    - pop the head and cnt--;
//    - raise inst_data_ok or data_data_ok in that same cycle, per the head ID.
//  - Accept and s_data_ok in the same cycle: push and pop both happen, cnt is unchanged.
//    This is legal at cnt==OUTS_DEPTH only if the pop frees a slot in the prior cycle. Full is evaluated on the registered cnt, so no accept happens at full.
//  - Full (cnt==OUTS_DEPTH): s_req=0 and both addr_ok=0. A pending lock stays set.
//  - Empty with s_data_ok: the pulse is dropped. Both data_ok stay 0 and cnt stays 0 (no underflow).
//  - Pointers are log2(OUTS_DEPTH) bits and wrap naturally. cnt is log2(OUTS_DEPTH)+1 bits.
//  - Reset mid-transaction discards FIFO contents. Late s_data_ok after reset is handled as the empty case.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - adds a 1-bit last-winner register (reset 0 = inst), updated on every accept;
//    - when both masters request with lock=0, the master that was not the last winner is granted.
//  ARB_RR_EN undefined: fixed priority, data over inst, and no last-winner register.
// TESTING
//  1. inst_req=1, addr=0x1FC00000, s_addr_ok=1 same cycle -> s_addr=0x1FC00000, inst_addr_ok=1.
//     Then s_data_ok=1, s_rdata=0x3C1D0001 -> inst_data_ok=1, rdata=0x3C1D0001.
//  2. Both req, data_wr=1, addr=0x80000010, wstrb=0xF:
//     - no macro: data granted, s_wr=1, data_addr_ok=1;
//     - with ARB_RR_EN and last winner=data: inst granted.
//  3. Lock: inst granted, s_addr_ok=0 for 3 cycles, then data_req rises -> s_addr stays the inst address until accept. Data is granted the next cycle.
//  4. Ordering (OUTS_DEPTH=2): accept inst, then data; cnt=2, third request sees s_req=0.
//     - 1st s_data_ok -> inst_data_ok only;
//     - 2nd s_data_ok -> data_data_ok only.
//  5. Simultaneous accept and s_data_ok at cnt=1 -> cnt stays 1, head ID is correct. s_data_ok at cnt=0 -> no data_ok.
//  6. resetn=0 for one cycle with cnt=2 -> cnt=0 and all outputs 0. The next s_data_ok is dropped.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - inst/data master arbiter onto one SRAM-like slave port with in-order ID FIFO (optional ARB_RR_EN)
module sram_req_arbiter #(
  parameter int OUTS_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [3:0]        s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [ADDR_W-1:0] s_rdata
);

  localparam int PTR_W = $clog2(OUTS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTS_DEPTH);

  // grant encoding: 0 = inst, 1 = data
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_lock;
  logic             r_grant;
  logic             r_fifo [OUTS_DEPTH];
`ifdef ARB_RR_EN
  logic             r_last;
`endif

  logic w_grant;
  logic w_sel_req;
  logic w_not_full;
  logic w_sreq;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_drive;

  // grant select: locked grant wins, otherwise data priority (or alternate on contention)
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_grant;
    end
`ifdef ARB_RR_EN
    else if (inst_req && data_req) begin
      w_grant = ~r_last;
    end
`endif
    else begin
      w_grant = data_req;
    end
  end

  // everything below is gated by resetn so the reset cycle shows all-zero outputs
  assign w_sel_req  = w_grant ? data_req : inst_req;
  assign w_not_full = (r_cnt != FULL_CNT);
  assign w_sreq     = resetn & w_sel_req & w_not_full;
  assign w_push     = w_sreq & s_addr_ok;
  assign w_pop      = resetn & s_data_ok & (r_cnt != '0);
  assign w_head     = r_fifo[r_rptr];
  assign w_drive    = resetn & w_sel_req;

  assign s_req        = w_sreq;
  assign inst_addr_ok = w_push & ~w_grant;
  assign data_addr_ok = w_push & w_grant;
  assign inst_data_ok = w_pop & ~w_head;
  assign data_data_ok = w_pop & w_head;
  assign rdata        = resetn ? s_rdata : '0;

  assign s_wr    = w_drive & w_grant & data_wr;
  assign s_size  = w_drive ? (w_grant ? data_size : 2'b10) : 2'b00;
  assign s_wstrb = (w_drive & w_grant) ? data_wstrb : 4'h0;
  assign s_addr  = w_drive ? (w_grant ? data_addr : inst_addr) : '0;
  assign s_wdata = (w_drive & w_grant) ? data_wdata : '0;

  // outstanding count, FIFO pointers and address-phase lock
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_lock  <= 1'b0;
      r_grant <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_sreq && !s_addr_ok) begin
        r_lock  <= 1'b1;
        r_grant <= w_grant;
      end else if (w_push) begin
        r_lock  <= 1'b0;
      end
    end
  end

  // requester ID storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_grant;
  end

`ifdef ARB_RR_EN
  // last accepted master, used to alternate under contention
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last <= 1'b0;
    end else if (w_push) begin
      r_last <= w_grant;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - table-driven bench for sram_req_arbiter (default build, fixed priority)
module tb_sram_req_arbiter;

  localparam logic [31:0] IA  = 32'h1FC0_0000;
  localparam logic [31:0] IA2 = 32'h1FC0_0040;
  localparam logic [31:0] DA  = 32'h8000_0010;
  localparam logic [31:0] WD  = 32'h1234_5678;
  localparam logic [31:0] RD  = 32'h3C1D_0001;
  localparam logic [1:0]  GN = 2'd0, GI = 2'd1, GD = 2'd2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int checks = 0;
  int errors = 0;

  sram_req_arbiter #(.OUTS_DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        sao, sdo;
    logic [31:0] srd;
    logic [4:0]  e_flags;  // {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [1:0]  e_g;      // master expected on the slave port
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rn, logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dd, logic sao, logic sdo,
                              logic [31:0] srd, logic [4:0] ef, logic [1:0] eg, logic [31:0] er);
    vec_t v;
    v.rn = rn; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.sao = sao; v.sdo = sdo; v.srd = srd; v.e_flags = ef; v.e_g = eg; v.e_rdata = er;
    return v;
  endfunction

  function automatic logic [107:0] expect_bus(vec_t v);
    logic        wr;
    logic [1:0]  sz;
    logic [3:0]  st;
    logic [31:0] ad, wd;
    wr = 1'b0; sz = 2'b00; st = 4'h0; ad = 32'h0; wd = 32'h0;
    if (v.e_g == GI) begin
      sz = 2'b10; ad = v.ia;
    end else if (v.e_g == GD) begin
      wr = v.dw; sz = 2'b10; st = 4'hF; ad = v.da; wd = v.dd;
    end
    return {v.e_flags, wr, sz, st, ad, wd, v.e_rdata};
  endfunction

  function automatic logic [107:0] actual_bus();
    return {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
            s_wr, s_size, s_wstrb, s_addr, s_wdata, rdata};
  endfunction

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    bit found;
    logic [107:0] act, exp;

    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_size = 2'b10; data_wstrb = 4'hF; data_addr = '0; data_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

    //            rn ir ia   dr dw da  dd  sao sdo srd            flags     g   rdata
    vecs.push_back(mk(0, 0, 0,   0, 0, 0,  0,  0, 0, 0,            5'b00000, GN, 0));            // reset
    vecs.push_back(mk(0, 1, IA,  1, 1, DA, WD, 1, 1, RD,           5'b00000, GN, 0));            // reset with busy inputs
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 0, 0,            5'b00000, GN, 0));            // idle after reset
    vecs.push_back(mk(1, 1, IA,  0, 0, 0,  0,  1, 0, 0,            5'b11000, GI, 0));            // inst accept
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, RD,           5'b00010, GN, RD));           // inst data
    vecs.push_back(mk(1, 1, IA,  1, 1, DA, WD, 1, 0, 0,            5'b10100, GD, 0));            // both: data wins
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, 32'hAAAA5555, 5'b00001, GN, 32'hAAAA5555)); // write done
    vecs.push_back(mk(1, 1, IA,  0, 0, 0,  0,  0, 0, 0,            5'b10000, GI, 0));            // lock start
    vecs.push_back(mk(1, 1, IA,  0, 0, 0,  0,  0, 0, 0,            5'b10000, GI, 0));
    vecs.push_back(mk(1, 1, IA,  0, 0, 0,  0,  0, 0, 0,            5'b10000, GI, 0));
    vecs.push_back(mk(1, 1, IA,  1, 0, DA, WD, 0, 0, 0,            5'b10000, GI, 0));            // data arrives, inst held
    vecs.push_back(mk(1, 1, IA,  1, 0, DA, WD, 1, 0, 0,            5'b11000, GI, 0));            // inst accepted
    vecs.push_back(mk(1, 1, IA,  1, 0, DA, WD, 1, 0, 0,            5'b10100, GD, 0));            // data next, cnt->2
    vecs.push_back(mk(1, 1, IA,  1, 0, DA, WD, 1, 0, 0,            5'b00000, GD, 0));            // full
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, 32'h11110001, 5'b00010, GN, 32'h11110001)); // head inst
    vecs.push_back(mk(1, 0, 0,   1, 1, DA, WD, 1, 1, 32'h22220002, 5'b10101, GD, 32'h22220002)); // push+pop cnt=1
    vecs.push_back(mk(1, 1, IA,  0, 0, 0,  0,  1, 0, 0,            5'b11000, GI, 0));            // cnt->2
    vecs.push_back(mk(1, 0, 0,   1, 0, DA, WD, 1, 0, 0,            5'b00000, GD, 0));            // full again
    vecs.push_back(mk(0, 1, IA,  0, 0, 0,  0,  0, 1, 32'h33330003, 5'b00000, GN, 0));            // reset at cnt=2
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, 32'h44440004, 5'b00000, GN, 32'h44440004)); // late data_ok dropped
    vecs.push_back(mk(1, 1, IA2, 0, 0, 0,  0,  1, 0, 0,            5'b11000, GI, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, 32'h55550005, 5'b00010, GN, 32'h55550005));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 1, 32'h66660006, 5'b00000, GN, 32'h66660006)); // empty drop
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,  0,  0, 0, 0,            5'b00000, GN, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      resetn = vecs[i].rn; inst_req = vecs[i].ir; inst_addr = vecs[i].ia;
      data_req = vecs[i].dr; data_wr = vecs[i].dw; data_addr = vecs[i].da;
      data_wdata = vecs[i].dd; s_addr_ok = vecs[i].sao; s_data_ok = vecs[i].sdo;
      s_rdata = vecs[i].srd;
      @(negedge clk);
      act = actual_bus();
      exp = expect_bus(vecs[i]);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec%0d actual=%h required=%h", i, act, exp);
      end
      @(posedge clk); #1;
    end

    // hand-written: long lock hold while data competes, then bounded accept and completion
    inst_req = 1'b1; inst_addr = IA2; data_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin data_req = 1'b1; data_addr = DA; data_wr = 1'b1; end
      @(negedge clk);
      check1($sformatf("lock_addr%0d", k), s_addr, IA2);
      check1($sformatf("lock_noaok%0d", k), {31'b0, inst_addr_ok | data_addr_ok}, 32'h0);
      @(posedge clk); #1;
    end
    s_addr_ok = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (inst_addr_ok && !data_addr_ok && s_addr == IA2) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check1("lock_accept", {31'b0, found}, 32'h1);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0;
    s_data_ok = 1'b1; s_rdata = RD;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (inst_data_ok && !data_data_ok && rdata == RD) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check1("lock_complete", {31'b0, found}, 32'h1);
    @(posedge clk); #1;
    s_data_ok = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
